aes_enc_iter: RTL and testbench



---
 rtl/aes_enc_iter.sv | 137 +++++++++++++
 tb/tb_aes_enc_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor, one shared round datapath (SUB wait + MIX update per round).
// Round keys are fetched combinationally through rk_idx/rkey from an external key-schedule store.
module aes_enc_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rkey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;
  localparam logic [3:0] NR_L = 4'(NR);
  state_t state_q;
  logic [127:0] st_q, sb_q, sr_d, mc_d;
  logic [3:0] rnd_q, rk_idx_q;
  logic in_ready_q, out_valid_q, busy_q;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2 = gmul(a, a);
    x3 = gmul(x2, a);
    x12 = gmul(gmul(x3, x3), gmul(x3, x3));
    x15 = gmul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
    inv = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return r;
  endfunction
  // byte index = row + 4*col; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int w = 0; w < 4; w++)
      for (int c = 0; c < 4; c++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction
  assign sr_d = shift_rows(sb_q);
  assign mc_d = mix_columns(sr_d);
  // sub_bytes register: no reset, only consumed in MIX after a stable SUB cycle
  always_ff @(posedge clk) sb_q <= sub_bytes(st_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q <= '0;
      rnd_q <= '0;
      rk_idx_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            st_q <= din ^ rkey;
            rnd_q <= 4'd1;
            rk_idx_q <= 4'd1;
            in_ready_q <= 1'b0;
            busy_q <= 1'b1;
            state_q <= SUB;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SUB: state_q <= MIX;
        MIX: begin
          if (rnd_q < NR_L) begin
            st_q <= mc_d ^ rkey;
            rnd_q <= rnd_q + 4'd1;
            rk_idx_q <= rnd_q + 4'd1;
            state_q <= SUB;
          end else begin
            st_q <= sr_d ^ rkey;
            rk_idx_q <= 4'd0;
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign rk_idx = rk_idx_q;
  assign dout = st_q;
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: table-driven AES-128 reference plus a cycle-level timing model, compared every cycle.
module tb_aes_enc_iter;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] din = '0, key = '0;
  logic [1407:0] rks = '0;
  logic in_ready, out_valid, busy;
  logic [3:0] rk_idx;
  logic [127:0] rkey, dout;
  int total = 0, bad = 0;
  logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  always #5 clk = ~clk;
  assign rkey = (rk_idx <= 4'd10) ? rks[1407-128*int'(rk_idx) -: 128] : '0;
  aes_enc_iter #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .rk_idx(rk_idx), .rkey(rkey), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .busy(busy));
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] sbv(input logic [7:0] b);
    return sbox_tab[2047-8*int'(b) -: 8];
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] f;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbv(t[31:24]), sbv(t[23:16]), sbv(t[15:8]), sbv(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) f[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return f;
  endfunction
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [1407:0] ks;
    logic [7:0] a[16];
    logic [7:0] t[16];
    logic [7:0] acc;
    logic [127:0] s;
    int m;
    ks = expand(k);
    s = pt ^ ks[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) a[i] = sbv(s[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) t[i] = a[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) begin
          acc = '0;
          for (int j = 0; j < 4; j++) begin
            m = (j - w + 4) % 4;
            acc ^= gm(m == 0 ? 8'd2 : m == 1 ? 8'd3 : 8'd1, t[4*c+j]);
          end
          a[4*c+w] = (r < 10) ? acc : t[4*c+w];
        end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i] ^ ks[1407-128*r-8*i -: 8];
    end
    return s;
  endfunction
  // timing model: m_cnt = -1 idle, 0..19 round cycles, 20 = result held
  int m_cnt = -1, cyc = 0, n_acc = 0, n_out = 0;
  bit m_rdy = 1'b0, m_zero = 1'b1, rec = 1'b0;
  logic [127:0] m_exp = '0;
  int acc_cyc[$];
  logic [127:0] got[$];
  logic [3:0] rk_log[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = -1;
      m_rdy = 1'b0;
      m_zero = 1'b1;
    end else begin
      cyc++;
      if (out_valid && out_ready) begin
        got.push_back(dout);
        n_out++;
      end
      if (m_cnt < 0) begin
        if (in_valid && m_rdy) begin
          m_cnt = 0;
          m_exp = aes_model(din, key);
          m_zero = 1'b0;
          n_acc++;
          acc_cyc.push_back(cyc);
        end
        m_rdy = 1'b1;
      end else if (m_cnt < 20) m_cnt++;
      else if (out_ready) m_cnt = -1;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rk_idx", rk_idx, 0);
      chk("rst_dout", dout, 0);
    end else begin
      chk("in_ready", in_ready, m_cnt < 0 && m_rdy);
      chk("busy", busy, m_cnt >= 0);
      chk("out_valid", out_valid, m_cnt == 20);
      chk("rk_idx", rk_idx, (m_cnt >= 0 && m_cnt < 20) ? 4'(m_cnt / 2 + 1) : 4'd0);
      if (m_cnt == 20) chk("dout", dout, m_exp);
      else if (m_zero) chk("dout_after_rst", dout, 0);
    end
    if (rec) rk_log.push_back(rk_idx);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_key(input logic [127:0] k);
    key = k;
    rks = expand(k);
  endtask
  task automatic send(input logic [127:0] d, input bit keep);
    int a;
    a = n_acc;
    din = d;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && n_acc == a; i++) step();
    chk("accept", n_acc, a + 1);
    in_valid = keep;
  endtask
  task automatic wait_out(input int tgt);
    for (int i = 0; i < 200 && n_out < tgt; i++) step();
    chk("out_wait", n_out, tgt);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 40 && !out_valid; i++) step();
    chk("valid_wait", out_valid, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    logic [1407:0] ks;
    logic [127:0] e3, pt3;
    logic [127:0] p4[4];
    int n0, a0;
    #1;
    ks = expand(B_KEY);
    chk("pin_rk10", ks[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_model_b", aes_model(B_PT, B_KEY), B_CT);
    chk("pin_model_c", aes_model(C_PT, C_KEY), C_CT);
    set_key(B_KEY);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", in_ready, 1);
    send(B_PT, 1'b0);
    wait_valid();
    chk("b_latency", cyc - acc_cyc[$], 20);
    wait_out(1);
    chk("b_ct", got[$], B_CT);
    set_key(C_KEY);
    rec = 1'b1;
    send(C_PT, 1'b0);
    wait_out(2);
    rec = 1'b0;
    chk("c_ct", got[$], C_CT);
    chk("rk_len", rk_log.size(), 22);
    for (int k = 0; k < 22 && k < rk_log.size(); k++)
      chk("rk_seq", rk_log[k], (k == 0 || k == 21) ? 4'd0 : 4'((k - 1) / 2 + 1));
    pt3 = 128'h0123456789abcdeffedcba9876543210;
    e3 = aes_model(pt3, C_KEY);
    n0 = n_out;
    out_ready = 1'b0;
    send(pt3, 1'b0);
    wait_valid();
    for (int i = 0; i < 15; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_dout", dout, e3);
      chk("hold_busy", busy, 1);
      chk("hold_in_ready", in_ready, 0);
      in_valid = (i >= 3 && i < 8);
      din = ~pt3;
      step();
    end
    in_valid = 1'b0;
    chk("hold_no_out", n_out, n0);
    out_ready = 1'b1;
    step();
    chk("rel_busy", busy, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_count", n_out, n0 + 1);
    chk("rel_ct", got[$], e3);
    p4[0] = 128'h00000000000000000000000000000000;
    p4[1] = 128'hffffffffffffffffffffffffffffffff;
    p4[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
    p4[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    n0 = n_out;
    a0 = n_acc;
    for (int k = 0; k < 4; k++) send(p4[k], k < 3);
    wait_out(n0 + 4);
    for (int k = 0; k < 4 && n0 + k < got.size(); k++) chk("b2b_ct", got[n0+k], aes_model(p4[k], C_KEY));
    for (int k = 0; k < 3 && a0 + k + 1 < acc_cyc.size(); k++)
      chk("b2b_gap", acc_cyc[a0+k+1] - acc_cyc[a0+k], 22);
    repeat (30) step();
    chk("b2b_no_extra", n_out, n0 + 4);
    chk("b2b_acc", n_acc, a0 + 4);
    set_key(B_KEY);
    n0 = n_out;
    send(C_PT, 1'b0);
    repeat (9) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_rk_idx", rk_idx, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send(B_PT, 1'b0);
    wait_out(n0 + 1);
    chk("post_rst_ct", got[$], B_CT);
    repeat (10) step();
    chk("post_rst_count", n_out, n0 + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
